// File: rtl/cpu_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Contents: XLEN, INSTR_BYTES, NOP_INSTR, DEFAULT_RESET_VECTOR, and the fetch halt FSM state type.
// No logic; imported by the fetch unit, its interface and its PC register.
package cpu_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Used only when misaligned-redirect checking is built in.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's control, instruction-memory and IF/ID signals.
// Ports: stall, redirect_valid/target in; imem_addr out and imem_rdata in; if_valid/instr/pc/pc4 out.
// With FETCH_MISALIGN_CHK_EN defined, if_misalign is also carried (fetch unit drives it).
interface fetch_unit_if;
  import cpu_pkg::*;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc4;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            if_misalign;
`endif

  // Fetch unit side.
  modport master (
    input  stall, redirect_valid, redirect_target, imem_rdata,
`ifdef FETCH_MISALIGN_CHK_EN
    output if_misalign,
`endif
    output imem_addr, if_valid, if_instr, if_pc, if_pc4
  );

  // Environment side: hazard unit, EX redirect, instruction memory, IF/ID register.
  modport slave (
    output stall, redirect_valid, redirect_target, imem_rdata,
`ifdef FETCH_MISALIGN_CHK_EN
    input  if_misalign,
`endif
    input  imem_addr, if_valid, if_instr, if_pc, if_pc4
  );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Fetch PC state: next sequential address, address of the data in flight, and its valid bit.
// Ports: clk, rst (async active-high); load/load_addr, advance; fetch_pc, resp_pc, resp_valid.
// Priority: load over advance; with neither asserted every register holds.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_addr,
  input  logic            advance,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] resp_pc,
  output logic            resp_valid
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_VECTOR;
      resp_pc    <= '0;
      resp_valid <= 1'b0;
    end else if (load) begin
      resp_pc    <= load_addr;
      fetch_pc   <= load_addr + XLEN'(INSTR_BYTES);
      resp_valid <= 1'b1;
    end else if (advance) begin
      // Increment wraps modulo 2^32 with no flag.
      resp_pc    <= fetch_pc;
      fetch_pc   <= fetch_pc + XLEN'(INSTR_BYTES);
      resp_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: sequential PC, stall replay, redirect squash, IF/ID presentation.
// Ports: clk, rst (async active-high), bus (fetch_unit_if.master). Optional FETCH_MISALIGN_CHK_EN
// adds if_misalign and a halt on misaligned redirect targets; otherwise target[1:0] is forced to 00.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          XLEN         = 32
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic            resp_valid;
  logic [XLEN-1:0] target_eff;
  logic [XLEN-1:0] addr_sel;
  logic            advance;
  logic            halt;

`ifdef FETCH_MISALIGN_CHK_EN
  fetch_state_t state_q;
  fetch_state_t state_d;

  // Misaligned targets are kept verbatim so the offending PC is visible downstream.
  assign target_eff = bus.redirect_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Only a redirect can enter or leave the halt state.
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = (bus.redirect_target[1:0] != 2'b00) ? ST_HALT : ST_RUN;
    end
  end

  assign halt            = (state_q == ST_HALT);
  assign bus.if_misalign = halt;
`else
  assign target_eff = bus.redirect_target & ~XLEN'(3);
  assign halt       = 1'b0;
`endif

  // Address select. Replaying resp_pc under stall keeps imem_rdata stable next cycle.
  always_comb begin
    addr_sel = fetch_pc;
    advance  = 1'b0;
    if (bus.redirect_valid) begin
      addr_sel = target_eff;
    end else if (halt || (bus.stall && resp_valid)) begin
      addr_sel = resp_pc;
    end else begin
      // Fill (stall with nothing in flight) and normal advance update identically.
      advance  = 1'b1;
    end
  end

  fetch_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (bus.redirect_valid),
    .load_addr  (addr_sel),
    .advance    (advance),
    .fetch_pc   (fetch_pc),
    .resp_pc    (resp_pc),
    .resp_valid (resp_valid)
  );

  assign bus.imem_addr = addr_sel;

  // Data returning during a redirect cycle belongs to the wrong path.
  assign bus.if_valid = resp_valid & ~bus.redirect_valid;
  assign bus.if_instr = (bus.if_valid && !halt) ? bus.imem_rdata : NOP_INSTR;
  assign bus.if_pc    = resp_pc;
  assign bus.if_pc4   = resp_pc + XLEN'(INSTR_BYTES);
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit_if ifa ();
  fetch_unit_if ifb ();

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .XLEN(32)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8), .XLEN(32)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  // Memory contents: mem[i] = i + 0x100, registered read, 0 while in reset.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {2'b00, addr[31:2]} + 32'h100;
  endfunction

  logic [31:0] rdata_a, rdata_b;
  always_ff @(posedge clk or posedge rst_a)
    if (rst_a) rdata_a <= '0; else rdata_a <= mem_word(ifa.imem_addr);
  always_ff @(posedge clk or posedge rst_b)
    if (rst_b) rdata_b <= '0; else rdata_b <= mem_word(ifb.imem_addr);
  assign ifa.imem_rdata = rdata_a;
  assign ifb.imem_rdata = rdata_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset_a();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    settle();
    checks++; if (ifa.if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp %h", ifa.if_valid, 1'b0); end
    checks++; if (ifa.if_instr !== 32'h13) begin errors++; $display("FAIL rst_instr got %h exp %h", ifa.if_instr, 32'h13); end
    checks++; if (ifa.if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", ifa.if_pc, 32'h0); end
    checks++; if (ifa.if_pc4 !== 32'h4) begin errors++; $display("FAIL rst_pc4 got %h exp %h", ifa.if_pc4, 32'h4); end
    checks++; if (ifb.imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL rst_addr_b got %h exp %h", ifb.imem_addr, 32'hFFFF_FFF8); end
    rst_a = 1'b0;
    settle();
    // Out of reset but before the first edge: nothing valid yet.
    checks++; if (ifa.if_valid !== 1'b0) begin errors++; $display("FAIL rel_valid got %h exp %h", ifa.if_valid, 1'b0); end
    checks++; if (ifa.imem_addr !== 32'h0) begin errors++; $display("FAIL rel_addr got %h exp %h", ifa.imem_addr, 32'h0); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = 32'(i * 4);
      checks++; if (ifa.if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %h exp %h", i, ifa.if_valid, 1'b1); end
      checks++; if (ifa.if_pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, ifa.if_pc, exp_pc); end
      checks++; if (ifa.if_instr !== 32'h100 + 32'(i)) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", i, ifa.if_instr, 32'h100 + 32'(i)); end
    end
  endtask

  task automatic test_stall();
    // if_pc is 8 here.
    ifa.stall = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ifa.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr[%0d] got %h exp %h", i, ifa.imem_addr, 32'h8); end
      checks++; if (ifa.if_pc !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got %h exp %h", i, ifa.if_pc, 32'h8); end
      checks++; if (ifa.if_instr !== 32'h102) begin errors++; $display("FAIL stall_instr[%0d] got %h exp %h", i, ifa.if_instr, 32'h102); end
      tick();
    end
    ifa.stall = 1'b0;
    settle();
    checks++; if (ifa.imem_addr !== 32'hC) begin errors++; $display("FAIL resume_addr got %h exp %h", ifa.imem_addr, 32'hC); end
    tick();
    checks++; if (ifa.if_pc !== 32'hC) begin errors++; $display("FAIL resume_pc got %h exp %h", ifa.if_pc, 32'hC); end
    checks++; if (ifa.if_instr !== 32'h103) begin errors++; $display("FAIL resume_instr got %h exp %h", ifa.if_instr, 32'h103); end
  endtask

  task automatic test_redirect();
    do_reset_a();
    repeat (2) tick();
    checks++; if (ifa.if_pc !== 32'h4) begin errors++; $display("FAIL redir_pre_pc got %h exp %h", ifa.if_pc, 32'h4); end
    ifa.redirect_valid  = 1'b1;
    ifa.redirect_target = 32'h40;
    settle();
    checks++; if (ifa.if_valid !== 1'b0) begin errors++; $display("FAIL redir_squash got %h exp %h", ifa.if_valid, 1'b0); end
    checks++; if (ifa.if_instr !== 32'h13) begin errors++; $display("FAIL redir_nop got %h exp %h", ifa.if_instr, 32'h13); end
    checks++; if (ifa.imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got %h exp %h", ifa.imem_addr, 32'h40); end
    tick();
    ifa.redirect_valid = 1'b0;
    settle();
    checks++; if (ifa.if_valid !== 1'b1) begin errors++; $display("FAIL redir_valid got %h exp %h", ifa.if_valid, 1'b1); end
    checks++; if (ifa.if_pc !== 32'h40) begin errors++; $display("FAIL redir_pc got %h exp %h", ifa.if_pc, 32'h40); end
    checks++; if (ifa.if_pc4 !== 32'h44) begin errors++; $display("FAIL redir_pc4 got %h exp %h", ifa.if_pc4, 32'h44); end
    checks++; if (ifa.if_instr !== 32'h110) begin errors++; $display("FAIL redir_instr got %h exp %h", ifa.if_instr, 32'h110); end
    checks++; if (ifa.imem_addr !== 32'h44) begin errors++; $display("FAIL redir_next_addr got %h exp %h", ifa.imem_addr, 32'h44); end
  endtask

  task automatic test_redirect_stall();
    ifa.stall           = 1'b1;
    ifa.redirect_valid  = 1'b1;
    ifa.redirect_target = 32'h80;
    settle();
    checks++; if (ifa.imem_addr !== 32'h80) begin errors++; $display("FAIL rs_addr got %h exp %h", ifa.imem_addr, 32'h80); end
    tick();
    ifa.redirect_valid = 1'b0;
    settle();
    for (int i = 0; i < 2; i++) begin
      checks++; if (ifa.if_valid !== 1'b1) begin errors++; $display("FAIL rs_valid[%0d] got %h exp %h", i, ifa.if_valid, 1'b1); end
      checks++; if (ifa.if_pc !== 32'h80) begin errors++; $display("FAIL rs_pc[%0d] got %h exp %h", i, ifa.if_pc, 32'h80); end
      checks++; if (ifa.if_instr !== 32'h120) begin errors++; $display("FAIL rs_instr[%0d] got %h exp %h", i, ifa.if_instr, 32'h120); end
      checks++; if (ifa.imem_addr !== 32'h80) begin errors++; $display("FAIL rs_addr_hold[%0d] got %h exp %h", i, ifa.imem_addr, 32'h80); end
      tick();
    end
    ifa.stall = 1'b0;
    tick();
    checks++; if (ifa.if_pc !== 32'h84) begin errors++; $display("FAIL rs_resume_pc got %h exp %h", ifa.if_pc, 32'h84); end
  endtask

  task automatic test_misalign();
    ifa.redirect_valid  = 1'b1;
    ifa.redirect_target = 32'h42;
    settle();
`ifdef FETCH_MISALIGN_CHK_EN
    checks++; if (ifa.imem_addr !== 32'h42) begin errors++; $display("FAIL mis_addr got %h exp %h", ifa.imem_addr, 32'h42); end
    tick();
    ifa.redirect_valid = 1'b0;
    settle();
    for (int i = 0; i < 2; i++) begin
      checks++; if (ifa.if_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag[%0d] got %h exp %h", i, ifa.if_misalign, 1'b1); end
      checks++; if (ifa.if_valid !== 1'b1) begin errors++; $display("FAIL mis_valid[%0d] got %h exp %h", i, ifa.if_valid, 1'b1); end
      checks++; if (ifa.if_instr !== 32'h13) begin errors++; $display("FAIL mis_instr[%0d] got %h exp %h", i, ifa.if_instr, 32'h13); end
      checks++; if (ifa.if_pc !== 32'h42) begin errors++; $display("FAIL mis_pc[%0d] got %h exp %h", i, ifa.if_pc, 32'h42); end
      checks++; if (ifa.imem_addr !== 32'h42) begin errors++; $display("FAIL mis_frozen[%0d] got %h exp %h", i, ifa.imem_addr, 32'h42); end
      tick();
    end
    ifa.redirect_valid  = 1'b1;
    ifa.redirect_target = 32'h50;
    tick();
    ifa.redirect_valid = 1'b0;
    settle();
    checks++; if (ifa.if_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %h exp %h", ifa.if_misalign, 1'b0); end
    checks++; if (ifa.if_pc !== 32'h50) begin errors++; $display("FAIL mis_new_pc got %h exp %h", ifa.if_pc, 32'h50); end
    checks++; if (ifa.if_instr !== 32'h114) begin errors++; $display("FAIL mis_new_instr got %h exp %h", ifa.if_instr, 32'h114); end
`else
    checks++; if (ifa.imem_addr !== 32'h40) begin errors++; $display("FAIL align_addr got %h exp %h", ifa.imem_addr, 32'h40); end
    tick();
    ifa.redirect_valid = 1'b0;
    settle();
    checks++; if (ifa.if_pc !== 32'h40) begin errors++; $display("FAIL align_pc got %h exp %h", ifa.if_pc, 32'h40); end
    checks++; if (ifa.if_instr !== 32'h110) begin errors++; $display("FAIL align_instr got %h exp %h", ifa.if_instr, 32'h110); end
    checks++; if (ifa.if_valid !== 1'b1) begin errors++; $display("FAIL align_valid got %h exp %h", ifa.if_valid, 1'b1); end
    checks++; if (ifa.imem_addr !== 32'h44) begin errors++; $display("FAIL align_next got %h exp %h", ifa.imem_addr, 32'h44); end
`endif
  endtask

  task automatic test_wrap_and_midreset();
    logic [31:0] exp_pc  [3];
    logic [31:0] exp_ins [3];
    logic [31:0] exp_pc4 [3];
    exp_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_ins = '{32'h4000_00FE, 32'h4000_00FF, 32'h0000_0100};
    exp_pc4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ifb.if_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d] got %h exp %h", i, ifb.if_valid, 1'b1); end
      checks++; if (ifb.if_pc !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d] got %h exp %h", i, ifb.if_pc, exp_pc[i]); end
      checks++; if (ifb.if_pc4 !== exp_pc4[i]) begin errors++; $display("FAIL wrap_pc4[%0d] got %h exp %h", i, ifb.if_pc4, exp_pc4[i]); end
      checks++; if (ifb.if_instr !== exp_ins[i]) begin errors++; $display("FAIL wrap_instr[%0d] got %h exp %h", i, ifb.if_instr, exp_ins[i]); end
    end
    rst_b = 1'b1;
    settle();
    checks++; if (ifb.if_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %h exp %h", ifb.if_valid, 1'b0); end
    checks++; if (ifb.if_instr !== 32'h13) begin errors++; $display("FAIL midrst_instr got %h exp %h", ifb.if_instr, 32'h13); end
    checks++; if (ifb.if_pc !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h exp %h", ifb.if_pc, 32'h0); end
    checks++; if (ifb.imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL midrst_addr got %h exp %h", ifb.imem_addr, 32'hFFFF_FFF8); end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.stall = 1'b0; ifa.redirect_valid = 1'b0; ifa.redirect_target = '0;
    ifb.stall = 1'b0; ifb.redirect_valid = 1'b0; ifb.redirect_target = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_misalign();
    test_wrap_and_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Initiator side of the instruction-fetch interface; drives the instruction memory's word address and consumes its registered read data.
- The memory returns mem[addr[31:2]] one cycle after the address is presented, and returns 0 while the memory is in reset.
- Generates the sequential PC, replays the address under stall, and squashes wrong-path data on redirect.
- Presents a valid instruction/PC pair to the IF/ID pipeline register.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset (word aligned).
- XLEN, 32, address/data width (fixed at 32; present for package consistency).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hazard unit hold request for the IF stage.
- redirect_valid  in  1  branch/jump taken from EX.
- redirect_target  in  32  new fetch address.
- imem_addr  out  32  address presented to the instruction memory this cycle (combinational).
- imem_rdata  in  32  memory data for the address presented in the previous cycle.
- if_valid  out  1  if_instr/if_pc hold a real instruction.
- if_instr  out  32  fetched instruction, or NOP when not valid.
- if_pc  out  32  address of if_instr.
- if_pc4  out  32  if_pc + 4, modulo 2^32.

Behaviour:
- State registers:
  - fetch_pc: next sequential address.
  - resp_pc: address whose data is on imem_rdata.
  - resp_valid.
- Reset (async, rst=1), values apply immediately:
  - fetch_pc=RESET_VECTOR, resp_pc=0, resp_valid=0.
  - Outputs: if_valid=0, if_instr=32'h0000_0013, if_pc=0, if_pc4=4, imem_addr=RESET_VECTOR.
- Outputs, combinational:
  - if_valid = resp_valid & ~redirect_valid.
  - if_instr = if_valid ? imem_rdata : NOP.
  - if_pc = resp_pc.
  - if_pc4 = resp_pc+4.
- Address select, priority order:
  - redirect_valid: imem_addr=redirect_target, with [1:0] forced to 00 unless the optional feature is enabled.
  - stall & resp_valid: imem_addr=resp_pc (replay, so imem_rdata is stable next cycle).
  - Otherwise: imem_addr=fetch_pc.
- Register update per edge:
  - redirect_valid (overrides stall): resp_pc<=imem_addr, fetch_pc<=imem_addr+4, resp_valid<=1. The data on imem_rdata in the redirect cycle is discarded.
  - stall & resp_valid: all registers hold.
  - stall & ~resp_valid: fill. resp_pc<=fetch_pc, fetch_pc<=fetch_pc+4, resp_valid<=1.
  - Otherwise: advance, same updates as fill.
- Latency:
  - First if_valid in the cycle after reset deasserts, with if_pc=RESET_VECTOR.
  - Redirect-to-valid target data: 1 cycle.
  - Throughput: 1 instruction/cycle.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 = 32'h0, no flag.
- Reset mid-operation clears resp_valid immediately; no partial data is ever marked valid.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output port if_misalign (1 bit), reset value 0.
  - A redirect whose target[1:0]!=0 loads resp_pc with the unmodified target.
  - Following cycle: if_valid=1, if_misalign=1, if_instr=NOP.
  - The unit then freezes: registers hold and imem_addr=resp_pc, until the next redirect, which clears if_misalign.
- Undefined: no port; target[1:0] is ignored (forced 00); no halt state.

Decomposition:
- cpu_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - DEFAULT_RESET_VECTOR.
  - XLEN.
  - INSTR_BYTES = 4.
- One natural sub-module, fetch_pc_reg:
  - Holds fetch_pc, resp_pc and resp_valid with the async reset.
  - Takes load/advance/hold controls from fetch_unit's select logic.

Test Plan:
- Reset, then run 4 cycles, no stall, imem preloaded mem[i]=i+0x100 -> if_pc 0,4,8,C; if_instr 0x100..0x103; if_valid=1 from the first post-reset cycle.
- Stall held 3 cycles while if_pc=8 -> imem_addr=8 each cycle; if_instr/if_pc stable at 0x102/8; resume shows if_pc=C next.
- redirect_valid with target 0x40 while if_pc=4 -> that cycle if_valid=0, imem_addr=0x40; next cycle if_pc=0x40, if_pc4=0x44, valid.
- redirect_valid and stall asserted together, target 0x80 -> redirect wins; next cycle if_pc=0x80, if_valid=1 (stall still high, then held).
- RESET_VECTOR=32'hFFFF_FFF8, run 3 cycles -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; rst pulsed mid-run -> if_valid=0 in the same cycle.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x42 -> next cycle if_misalign=1, if_instr=NOP, imem_addr frozen at 0x42; redirect to 0x50 clears if_misalign. Without the macro the same target fetches 0x40.
